// File: rtl/subleq_sub_pipe.sv
// SUBLEQ subtract unit: two-stage valid/ready pipeline computing
// in_b - in_a with signed overflow flag, optional saturation, a
// "result <= 0" branch flag and a saturating overflow event counter.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand handshake, in_a (subtrahend), in_b (minuend)
//   out_valid/out_ready     result handshake, out_diff, out_ovf, out_leq
//   ovf_clr                 synchronous clear of ovf_count
//   ovf_count               overflowed results delivered (sticks at all-ones)
module subleq_sub_pipe #(
    parameter int WIDTH  = 8,
    parameter int SAT_EN = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_ovf,
    output logic             out_leq,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // S1: captured operands
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // S2: computed result
    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             ovf_q, ovf_d;
    logic             leq_q, leq_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             s2_load;
    logic [WIDTH-1:0] raw;
    logic             raw_ovf;
    logic [WIDTH-1:0] res;

    // Result datapath from the S1 operands
    always_comb begin
        raw     = b_q - a_q;
        // Overflow only possible when operand signs differ; it shows up
        // as the result sign disagreeing with the minuend sign.
        raw_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                  (raw[WIDTH-1] != b_q[WIDTH-1]);
        res     = raw;
        if (SAT_EN != 0 && raw_ovf) begin
            res = b_q[WIDTH-1] ? MOST_NEG : MOST_POS;
        end
    end

    // Handshake: S2 frees up in the same cycle its result is taken,
    // which lets in_ready depend combinationally on out_ready.
    always_comb begin
        out_xfer = s2_vld_q && out_ready;
        s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
        in_ready = !s1_vld_q || s2_load;
        in_xfer  = in_valid && in_ready;
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        a_d      = a_q;
        b_d      = b_q;
        if (in_xfer) begin
            s1_vld_d = 1'b1;
            a_d      = in_a;
            b_d      = in_b;
        end else if (s2_load) begin
            s1_vld_d = 1'b0;
        end
    end

    always_comb begin
        s2_vld_d = s2_vld_q;
        diff_d   = diff_q;
        ovf_d    = ovf_q;
        leq_d    = leq_q;
        if (s2_load) begin
            s2_vld_d = 1'b1;
            diff_d   = res;
            ovf_d    = raw_ovf;
            leq_d    = res[WIDTH-1] || (res == '0);
        end else if (out_xfer) begin
            s2_vld_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle increment
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr) begin
            cnt_d = '0;
        end else if (out_xfer && ovf_q && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s2_vld_q <= 1'b0;
            diff_q   <= '0;
            ovf_q    <= 1'b0;
            leq_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s2_vld_q <= s2_vld_d;
            diff_q   <= diff_d;
            ovf_q    <= ovf_d;
            leq_q    <= leq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_diff  = diff_q;
    assign out_ovf   = ovf_q;
    assign out_leq   = leq_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_subleq_sub_pipe.sv
// Testbench for subleq_sub_pipe: four configurations share one stimulus
// stream; each has its own expected-result queue and monitor.
module tb_subleq_sub_pipe;

    localparam int NI = 4;
    localparam int W_T [NI] = '{8, 8, 13, 13};
    localparam int S_T [NI] = '{0, 1, 0, 1};
    localparam int C_T [NI] = '{2, 8, 8, 8};

    typedef struct {
        int d;
        int o;
        int l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        ovf_clr = 1'b0;
    logic [12:0] a_all = '0;
    logic [12:0] b_all = '0;
    logic        end_chk = 1'b0;

    logic [NI-1:0] rdy_a;
    logic [NI-1:0] vld_a;
    logic [NI-1:0] ovf_a;
    logic [NI-1:0] leq_a;
    int            diff_i [NI];
    int            cnt_i  [NI];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference: signed integer arithmetic, then wrap or clamp to w bits.
    function automatic exp_t ref_model(input int w, input int s,
                                       input int a, input int b);
        exp_t r;
        int m, hi, lo, ai, bi, d;
        m  = 1 << w;
        hi = m / 2 - 1;
        lo = -(m / 2);
        ai = a & (m - 1);
        bi = b & (m - 1);
        if (ai > hi) ai -= m;
        if (bi > hi) bi -= m;
        d = bi - ai;
        r.o = (d > hi || d < lo) ? 1 : 0;
        if (d > hi) d = (s != 0) ? hi : d - m;
        if (d < lo) d = (s != 0) ? lo : d + m;
        r.d = d;
        r.l = (d <= 0) ? 1 : 0;
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int W = W_T[g];
        localparam int S = S_T[g];
        localparam int C = C_T[g];
        localparam int CMAX = (1 << C) - 1;

        logic         rdy, vld, ovf, leq;
        logic [W-1:0] diff;
        logic [C-1:0] cnt;
        logic signed [W-1:0] sd;

        subleq_sub_pipe #(
            .WIDTH (W),
            .SAT_EN(S),
            .CNT_W (C)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (rdy),
            .in_a     (a_all[W-1:0]),
            .in_b     (b_all[W-1:0]),
            .out_valid(vld),
            .out_ready(out_ready),
            .out_diff (diff),
            .out_ovf  (ovf),
            .out_leq  (leq),
            .ovf_clr  (ovf_clr),
            .ovf_count(cnt)
        );

        assign sd        = diff;
        assign rdy_a[g]  = rdy;
        assign vld_a[g]  = vld;
        assign ovf_a[g]  = ovf;
        assign leq_a[g]  = leq;
        assign diff_i[g] = sd;
        assign cnt_i[g]  = 32'(cnt);

        exp_t q[$];
        exp_t e;
        int   cnt_e = 0;
        bit   hold = 0;
        int   h_d, h_o, h_l;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                cnt_e = 0;
                hold  = 0;
                chk($sformatf("u%0d_rst_vld", g), int'(vld), 0);
                chk($sformatf("u%0d_rst_rdy", g), int'(rdy), 1);
                chk($sformatf("u%0d_rst_cnt", g), int'(cnt), 0);
                chk($sformatf("u%0d_rst_diff", g), int'(sd), 0);
            end else begin
                chk($sformatf("u%0d_cnt", g), int'(cnt), cnt_e);
                if (hold) begin
                    chk($sformatf("u%0d_hold_vld", g), int'(vld), 1);
                    chk($sformatf("u%0d_hold_diff", g), int'(sd), h_d);
                    chk($sformatf("u%0d_hold_ovf", g), int'(ovf), h_o);
                    chk($sformatf("u%0d_hold_leq", g), int'(leq), h_l);
                end
                if (vld && out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("u%0d_unexpected_out", g), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("u%0d_diff", g), int'(sd), e.d);
                        chk($sformatf("u%0d_ovf", g), int'(ovf), e.o);
                        chk($sformatf("u%0d_leq", g), int'(leq), e.l);
                        if (!ovf_clr && e.o != 0 && cnt_e < CMAX) cnt_e++;
                    end
                end
                if (ovf_clr) cnt_e = 0;
                if (in_valid && rdy) begin
                    q.push_back(ref_model(W, S, int'(a_all), int'(b_all)));
                end
                hold = vld && !out_ready;
                h_d  = sd;
                h_o  = int'(ovf);
                h_l  = int'(leq);
            end
        end

        always @(negedge rst_n) begin
            #1;
            chk($sformatf("u%0d_async_vld", g), int'(vld), 0);
            chk($sformatf("u%0d_async_cnt", g), int'(cnt), 0);
        end

        always @(posedge end_chk) begin
            chk($sformatf("u%0d_drained", g), q.size(), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int vb [5] = '{125, -110, 125, 12, -126};
    int va [5] = '{-123, -9, 0, 12, 12};
    int e0d[5] = '{-8, -101, 125, 0, 118};
    int e0o[5] = '{1, 0, 0, 0, 1};
    int e0l[5] = '{1, 1, 0, 1, 0};
    int e1d[5] = '{127, -101, 125, 0, -128};
    int e1o[5] = '{1, 0, 0, 0, 1};
    int e1l[5] = '{0, 1, 0, 1, 1};

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, one at a time, with latency check
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            b_all = 13'(vb[i]);
            a_all = 13'(va[i]);
            @(negedge clk);
            chk("dir_in_ready", int'(rdy_a[0]), 1);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk("dir_lat_early", int'(vld_a[0]), 0);
            @(negedge clk);
            chk("dir_lat_vld", int'(vld_a[0]), 1);
            chk("dir_w0_diff", diff_i[0], e0d[i]);
            chk("dir_w0_ovf", int'(ovf_a[0]), e0o[i]);
            chk("dir_w0_leq", int'(leq_a[0]), e0l[i]);
            chk("dir_s1_diff", diff_i[1], e1d[i]);
            chk("dir_s1_ovf", int'(ovf_a[1]), e1o[i]);
            chk("dir_s1_leq", int'(leq_a[1]), e1l[i]);
            step();
        end

        // Backpressure: only two operands fit
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        repeat (6) begin
            a_all = 13'($urandom);
            b_all = 13'($urandom);
            @(negedge clk);
            if (rdy_a[0]) acc++;
            step();
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", int'(rdy_a[0]), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("bp_drain_vld", int'(vld_a[0]), 0);

        // Counter saturation (CNT_W=2) and clear priority
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        b_all = 13'(125);
        a_all = 13'(-123);
        in_valid = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("cnt_sat", cnt_i[0], 3);
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("clr_pre_vld", int'(vld_a[0]), 1);
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_priority", cnt_i[0], 0);
        chk("clr_vld", int'(vld_a[0]), 0);

        // Reset with both stages full and a nonzero counter
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("pre_rst_cnt", cnt_i[0], 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (2) step();
        in_valid = 1'b0;
        chk("pre_rst_vld", int'(vld_a[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_now_vld", int'(vld_a[0]), 0);
        chk("rst_now_cnt", cnt_i[0], 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", int'(vld_a[0]), 0);
        end
        step();

        // Random stream
        repeat (2500) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            ovf_clr   = ($urandom % 64) == 0;
            a_all = 13'($urandom);
            b_all = 13'($urandom);
            step();
        end

        in_valid = 1'b0;
        ovf_clr = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        end_chk = 1'b1;
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/subleq_sub_pipe.md
SUBLEQ_SUB_PIPE -- requirements
Module: subleq_sub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have parameter SAT_EN, default 0: 0 = wrap on overflow, 1 = saturate on overflow.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the overflow event counter width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operand pair offered.
REQ-008 in_ready  output  1  block accepts operand pair this cycle.
REQ-009 in_a  input  WIDTH  signed subtrahend (SUBLEQ mem[A]).
REQ-010 in_b  input  WIDTH  signed minuend (SUBLEQ mem[B]).
REQ-011 out_valid  output  1  result held on outputs.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 out_diff  output  WIDTH  signed result.
REQ-014 out_ovf  output  1  signed overflow occurred for this result.
REQ-015 out_leq  output  1  out_diff as signed is less than or equal to 0 (SUBLEQ branch-taken).
REQ-016 ovf_clr  input  1  synchronous clear of ovf_count.
REQ-017 ovf_count  output  CNT_W  number of overflowed results delivered.

Function
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-019 The datapath SHALL have two register stages: S1 captures in_a/in_b, and S2 holds the computed result; each stage has its own valid bit.
REQ-020 With no backpressure, out_valid SHALL assert 2 cycles after the edge that accepted the input.
REQ-021 S2 SHALL load when S1 is valid and either S2 is empty or an output transfer occurs in the same cycle.
REQ-022 in_ready SHALL equal (S1 empty) OR (S2 loads this cycle), so a stall-free stream sustains one transfer per cycle; a combinational path from out_ready to in_ready is permitted.
REQ-023 Results SHALL be delivered in acceptance order, with no loss or duplication under any pattern of in_valid and out_ready.
REQ-024 While out_valid=1 and out_ready=0, out_diff, out_ovf and out_leq SHALL remain stable.
REQ-025 The raw difference SHALL be in_b minus in_a, computed modulo 2^WIDTH.
REQ-026 out_ovf SHALL be 1 when sign(in_a) differs from sign(in_b) and the sign of the raw difference differs from sign(in_b).
REQ-027 With SAT_EN=0, out_diff SHALL be the raw difference.
REQ-028 With SAT_EN=1 and overflow, out_diff SHALL be the most negative value if in_b is negative, otherwise the most positive value; out_ovf SHALL still read 1.
REQ-029 out_leq SHALL be computed from the final out_diff (after saturation, if enabled).
REQ-030 ovf_count SHALL increment by 1 on each output transfer with out_ovf=1.
REQ-031 ovf_count SHALL hold at its all-ones value rather than wrap.
REQ-032 When ovf_clr=1, ovf_count SHALL become 0 on that edge; clear takes priority over a simultaneous increment, and that increment is lost.
REQ-033 in_a and in_b SHALL be ignored when no input transfer occurs.

Reset
REQ-034 While rst_n=0, the S1 and S2 valid bits, out_valid, out_diff, out_ovf, out_leq and ovf_count SHALL be 0, and in_ready SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight operands and results, with no output transfer of them after release.
REQ-036 The first input transfer SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-037 WIDTH=8, SAT_EN=0, out_ready=1: (b=125, a=-123) -> out_diff=0xF8 (-8), ovf=1, leq=1; (b=-110, a=-9) -> -101, ovf=0, leq=1; (b=125, a=0) -> 125, ovf=0, leq=0; (b=12, a=12) -> 0, leq=1; each result appears 2 cycles after acceptance.
REQ-038 WIDTH=8, SAT_EN=1: (b=125, a=-123) -> out_diff=127, ovf=1, leq=0; (b=-126, a=12) -> out_diff=-128, ovf=1, leq=1; the same input with SAT_EN=0 -> 118 (0x76), ovf=1, leq=0.
REQ-039 Backpressure: hold out_ready=0 with in_valid=1 continuously -> exactly 2 inputs accepted and in_ready=0 thereafter; release out_ready -> all results emerge in order with none dropped.
REQ-040 Counter (CNT_W=2): deliver 4 overflowing results -> ovf_count holds at 3; assert ovf_clr in the same cycle as an overflowing output transfer -> ovf_count=0.
REQ-041 Assert rst_n=0 with S1 and S2 both valid -> out_valid=0 and ovf_count=0 immediately; after release, no stale result appears.
REQ-042 Random stream of 1000 operand pairs with random in_valid and out_ready, for WIDTH 8 and 13 and both SAT_EN values -> every output matches a reference model of REQ-025..REQ-029, in order.
